// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, default window base and seven-segment decode for mmio_hub
package mmio_pkg;
  localparam logic [31:0] ADDR_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam logic [2:0] OFF_SW       = 3'd0;
  localparam logic [2:0] OFF_LED      = 3'd1;
  localparam logic [2:0] OFF_SEG_DATA = 3'd2;
  localparam logic [2:0] OFF_SEG_MASK = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      default: hex7 = 8'h8E;
    endcase
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus stability counter for the switch bank
module sw_debounce #(
  parameter int N_SW            = 16,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_i,
  output logic [N_SW-1:0] stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N_SW-1:0] s1_q, s2_q, cand_q, cand_d, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic diff, done;
  // restart the count on any candidate change, accept the candidate once it has held long enough
  always_comb begin
    diff     = s2_q != cand_q;
    done     = cnt_q == CMAX;
    cand_d   = s2_q;
    cnt_d    = diff ? '0 : done ? cnt_q : cnt_q + 1'b1;
    stable_d = (!diff && done) ? cand_q : stable_q;
  end
  // synchroniser and debounce state, cleared by active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign stable_o = stable_q;
endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: MMIO window for switches, LEDs and scanned seven-segment display; MMIO_SW_CHANGE_IRQ_EN adds the switch-change flag and irq
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int          N_SW            = 16,
  parameter int          N_LED           = 16,
  parameter int          N_DIGITS        = 8,
  parameter int          DEBOUNCE_CYCLES = 2_000_000,
  parameter int          SCAN_DIV        = 100_000,
  parameter logic [31:0] ADDR_BASE       = ADDR_BASE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         bus_addr,
  input  logic [31:0]         bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [31:0]         bus_rdata,
  output logic                bus_ready,
  input  logic [N_SW-1:0]     switch,
  output logic [N_LED-1:0]    led,
  output logic [7:0]          seg_out,
  output logic [N_DIGITS-1:0] tub_sel,
  output logic                irq
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(N_DIGITS - 1);

  logic [N_SW-1:0] sw_stable;
  logic hit, wr, rd, acc, sw_changed, unused;
  logic [2:0] off;
  logic [31:0] rd_val, rdata_q, rdata_d, seg_data_q, seg_data_d;
  logic ready_q, ready_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_DIGITS-1:0] mask_q, mask_d, tub_q, tub_d;
  logic [DW-1:0] div_q, div_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] nib;

  sw_debounce #(.N_SW(N_SW), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (switch),
    .stable_o (sw_stable)
  );

  assign unused = ^bus_addr[1:0];

  // decode, register read mux and next state of the bus-visible registers
  always_comb begin
    hit        = bus_addr[31:5] == ADDR_BASE[31:5];
    off        = bus_addr[4:2];
    wr         = bus_we & hit;
    rd         = bus_re & ~bus_we & hit;
    acc        = (bus_we | bus_re) & hit;
    rd_val     = off == OFF_SW       ? 32'(sw_stable) :
                 off == OFF_LED      ? 32'(led_q) :
                 off == OFF_SEG_DATA ? seg_data_q :
                 off == OFF_SEG_MASK ? 32'(mask_q) :
                 off == OFF_STATUS   ? 32'(sw_changed) : '0;
    ready_d    = acc;
    rdata_d    = rd ? rd_val : '0;
    led_d      = (wr && off == OFF_LED) ? bus_wdata[N_LED-1:0] : led_q;
    seg_data_d = (wr && off == OFF_SEG_DATA) ? bus_wdata : seg_data_q;
    mask_d     = (wr && off == OFF_SEG_MASK) ? bus_wdata[N_DIGITS-1:0] : mask_q;
  end

  // scan divider, digit index and the registered segment/enable pattern for the current digit
  always_comb begin
    div_d = div_q == DMAX ? '0 : div_q + 1'b1;
    idx_d = div_q != DMAX ? idx_q : idx_q == IMAX ? '0 : idx_q + 1'b1;
    nib   = seg_data_q[{idx_q, 2'b00} +: 4];
    seg_d = mask_q[idx_q] ? hex7(nib) : 8'hFF;
    tub_d = mask_q[idx_q] ? ~(N_DIGITS'(1) << idx_q) : '1;
  end

  // bus, register and scanner state
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      led_q      <= '0;
      seg_data_q <= '0;
      mask_q     <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      seg_q      <= 8'hFF;
      tub_q      <= '1;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      seg_data_q <= seg_data_d;
      mask_q     <= mask_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      tub_q      <= tub_d;
    end
  end

`ifdef MMIO_SW_CHANGE_IRQ_EN
  logic [N_SW-1:0] sw_prev_q;
  logic flag_q, flag_d;
  // sticky change flag: a set wins over a same-cycle write-1 clear
  always_comb begin
    flag_d = (sw_stable != sw_prev_q) |
             (flag_q & ~(wr && off == OFF_STATUS && bus_wdata[0]));
  end
  // previous debounced value and the sticky flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_prev_q <= '0;
      flag_q    <= 1'b0;
    end else begin
      sw_prev_q <= sw_stable;
      flag_q    <= flag_d;
    end
  end
  assign sw_changed = flag_q;
  assign irq        = flag_q;
`else
  assign sw_changed = 1'b0;
  assign irq        = 1'b0;
`endif

  assign bus_ready = ready_q;
  assign bus_rdata = rdata_q;
  assign led       = led_q;
  assign seg_out   = seg_q;
  assign tub_sel   = tub_q;
endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
Parametrised memory-mapped I/O hub between the CPU data-memory port and board peripherals: switches, LEDs and a multiplexed seven-segment display.
- Decodes a fixed address window and answers reads and writes with a one-cycle registered handshake.
- Debounces the switch bank.
- Scans N_DIGITS seven-segment digits from a 32-bit hex register.
- Replaces the fixed-width switch/LED control path of the single-cycle core with one configurable block.

Parameters:
N_SW, 16, switch count (1..32)
N_LED, 16, LED count (1..32)
N_DIGITS, 8, seven-segment digits (1..8)
DEBOUNCE_CYCLES, 2_000_000, stable cycles required before the switch value is accepted (>=2)
SCAN_DIV, 100_000, clk cycles per digit slot (>=2)
ADDR_BASE, 32'hFFFF_FC00, word-aligned base of the 32-byte window

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
bus_addr  in  32  byte address from CPU
bus_wdata  in  32  write data
bus_we  in  1  write strobe, single-cycle pulse
bus_re  in  1  read strobe, single-cycle pulse
bus_rdata  out  32  read data, valid while bus_ready=1
bus_ready  out  1  one-cycle acknowledge
switch  in  N_SW  raw asynchronous switch inputs
led  out  N_LED  LED drive, active-high
seg_out  out  8  segments {dp,g..a}, active-low
tub_sel  out  N_DIGITS  digit enables, active-low
irq  out  1  switch-change interrupt (MMIO_SW_CHANGE_IRQ_EN only, else tied 0)

Behaviour:
- Reset (rst=0 at posedge): all outputs are forced to their reset values on that edge.
  - led=0, bus_ready=0, bus_rdata=0, seg_out=8'hFF, tub_sel=all 1, irq=0.
  - Internal state cleared: seg_data, seg_mask, sw_stable, debounce counter, scan counter, digit index, sync flops.
  - Reset asserted mid-transaction drops the pending acknowledge.
- Address decode:
  - hit = (bus_addr[31:5] == ADDR_BASE[31:5]); offset = bus_addr[4:2]; bus_addr[1:0] ignored.
  - Register map by offset:
    - 0x00 SW, RO: zero-extended sw_stable.
    - 0x04 LED, RW: low N_LED bits.
    - 0x08 SEG_DATA, RW: 32 bits.
    - 0x0C SEG_MASK, RW: low N_DIGITS bits.
    - 0x10 STATUS, RW1C: bit0 = sw_changed, optional feature only, otherwise reads 0.
  - Other offsets inside the window: reads return 0, writes are ignored, and the access is still acknowledged.
- Handshake:
  - A strobe with hit in cycle T gives bus_ready=1 in T+1 for exactly one cycle.
  - For reads, bus_rdata holds the value sampled at the T edge; bus_rdata is 0 whenever bus_ready=0.
  - Back-to-back strobes on consecutive cycles are each acknowledged; there is no stall.
  - Writes update the register at the T edge, so a read in T+1 sees the new value.
  - bus_we and bus_re together: treated as a write, and bus_rdata=0 on the acknowledge.
  - Strobe without hit: no acknowledge, no state change.
- Switch debounce:
  - Two-flop synchroniser feeds the candidate register.
  - If the synchronised value != candidate: candidate <= synchronised value, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: sw_stable <= candidate, counter holds.
  - Else counter++.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Display scan:
  - Divider counts 0..SCAN_DIV-1. On wrap, digit index advances and wraps from N_DIGITS-1 to 0.
  - tub_sel[idx]=0 only if seg_mask[idx]=1; all other bits are 1.
  - seg_out = active-low hex decode of seg_data[4*idx+3:4*idx]; dp=1 (off).
  - With the mask bit clear, seg_out=8'hFF.
  - seg_out and tub_sel are registered; both change on the same edge.
  - N_DIGITS=1: the index stays 0.

Optional Feature:
MMIO_SW_CHANGE_IRQ_EN.
- Defined:
  - The STATUS bit0 sticky flag sets on any cycle where sw_stable changes value.
  - Writing 1 to STATUS bit0 clears it; a set and a clear in the same cycle leave it set.
  - irq = sticky flag, registered.
- Undefined:
  - No flag logic; STATUS reads 0; irq is constant 0.

Decomposition:
- Package mmio_pkg holds:
  - Offset constants OFF_SW, OFF_LED, OFF_SEG_DATA, OFF_SEG_MASK, OFF_STATUS.
  - Default ADDR_BASE.
  - A seven-segment hex decode function (nibble -> 8-bit active-low pattern).
- One sub-module, sw_debounce (parameters N_SW, DEBOUNCE_CYCLES), containing the synchroniser and the counter.
- The scanner stays inline.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> led=0, seg_out=8'hFF, tub_sel=8'hFF, bus_ready=0, irq=0.
- LED access: write 0x0000_A5A5 to 0xFFFF_FC04, then read the same address next cycle -> led=16'hA5A5; bus_ready pulses one cycle after each strobe; rdata=0x0000_A5A5.
- Switch debounce (DEBOUNCE_CYCLES=8):
  - switch=16'h00F0 with a glitch at cycle 4 -> SW read stays 0 until 8 stable cycles after the glitch, then 0x0000_00F0.
  - With the feature on, irq=1 afterwards; writing 1 to 0xFFFF_FC10 drops irq the next cycle.
- Display (SCAN_DIV=4):
  - SEG_DATA=0x1234_5678, SEG_MASK=8'h0F -> digit 0 shows 8 (seg_out=8'h80, tub_sel=8'hFE) and advances every 4 cycles.
  - Digits 4..7 give tub_sel=8'hFF, seg_out=8'hFF.
  - Index wraps from 7 to 0.
- Decode edges:
  - Access to 0xFFFF_FC1C -> acknowledged, rdata=0.
  - Access to 0xFFFF_FB00 -> no bus_ready.
  - we and re together on LED -> LED written, rdata=0.
- Back-to-back: read SW, LED, SEG_DATA on 3 consecutive cycles -> 3 consecutive bus_ready pulses with the matching data in order.
